// File: rtl/pokemon_pkg.sv
// Shared battle-screen constants: screen geometry, projectile width and default sprite sizes.
package pokemon_pkg;
   localparam int SCREEN_W     = 96;
   localparam int SCREEN_H     = 64;
   localparam int Y_W          = $clog2(SCREEN_H);
   localparam int PROJ_W       = 4;
   localparam int DEF_TARGET_W = 22;
   localparam int DEF_TARGET_H = 20;
   localparam int DEF_PROJ_H   = 5;

   function automatic logic spans_overlap(input int a_lo, input int a_hi,
                                          input int b_lo, input int b_hi);
      return (a_lo <= b_hi) && (b_lo <= a_hi);
   endfunction
endpackage

// File: rtl/projectile_pool_if.sv
// Control inputs and display/health outputs of one attacker's projectile pool.
interface projectile_pool_if #(
   parameter int N_SLOTS = 12,
   parameter int X_W     = 7
);
   import pokemon_pkg::*;

   logic                     clear;
   logic                     move_tick;
   logic                     shoot;
   logic [Y_W-1:0]           shoot_y;
   logic [Y_W-1:0]           target_top_y;
   logic                     shield_active;
   logic [N_SLOTS-1:0]       slot_en;
   logic [N_SLOTS*X_W-1:0]   slot_x;
   logic [N_SLOTS*Y_W-1:0]   slot_y;
   logic                     hit;
   logic                     blocked;
   logic [7:0]               health;
   logic                     alive;
   logic                     full;

   modport slave (
      input  clear, move_tick, shoot, shoot_y, target_top_y, shield_active,
      output slot_en, slot_x, slot_y, hit, blocked, health, alive, full
   );

   modport master (
      output clear, move_tick, shoot, shoot_y, target_top_y, shield_active,
      input  slot_en, slot_x, slot_y, hit, blocked, health, alive, full
   );
endinterface

// File: rtl/free_slot_finder.sv
// Lowest-set-bit priority encoder: picks the lowest-index free projectile slot.
module free_slot_finder #(
   parameter int N     = 12,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     free_mask,
   output logic [IDX_W-1:0] index,
   output logic             found
);
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            index = IDX_W'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/projectile_pool.sv
// Projectile slot manager for one attacker: spawns shots, moves them on move_tick,
// resolves hits/blocks against the defender sprite and tracks defender health.
module projectile_pool
   import pokemon_pkg::*;
#(
   parameter int N_SLOTS    = 12,
   parameter int X_W        = 7,
   parameter int SPAWN_X    = 10,
   parameter bit DIR        = 1'b1,
   parameter int SPEED      = 1,
   parameter int TARGET_X   = 74,
   parameter int TARGET_W   = DEF_TARGET_W,
   parameter int TARGET_H   = DEF_TARGET_H,
   parameter int PROJ_H     = DEF_PROJ_H,
   parameter int COOLDOWN   = 8,
   parameter int HEALTH_MAX = 100,
   parameter int DAMAGE     = 5
) (
   input  logic             single_pulse_clk,
   input  logic             reset,
   projectile_pool_if.slave pool
);
   localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic [N_SLOTS-1:0]     en_q, en_d;
   logic [N_SLOTS*X_W-1:0] x_q, x_d;
   logic [N_SLOTS*Y_W-1:0] y_q, y_d;
   logic [CD_W-1:0]        cd_q, cd_d;
   logic [7:0]             health_q, health_d;
   logic                   hit_q, blocked_q, alive_q, full_q;
   logic [N_SLOTS-1:0]     hit_vec, blk_vec;
   logic [IDX_W-1:0]       free_idx;
   logic                   free_found;
   logic                   accept;
   logic [9:0]             dmg;
   int                     nx;
   int                     k;

   free_slot_finder #(.N(N_SLOTS), .IDX_W(IDX_W)) u_finder (
      .free_mask (~en_q),
      .index     (free_idx),
      .found     (free_found)
   );

   always_comb begin
      en_d    = en_q;
      x_d     = x_q;
      y_d     = y_q;
      hit_vec = '0;
      blk_vec = '0;
      nx      = 0;
      k       = 0;

      if (pool.move_tick) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            if (en_q[i]) begin
               nx = DIR ? int'(x_q[i*X_W +: X_W]) + SPEED
                        : int'(x_q[i*X_W +: X_W]) - SPEED;
               if (nx < 0 || nx >= SCREEN_W) begin
                  en_d[i] = 1'b0;
               end else if (spans_overlap(nx, nx + PROJ_W - 1,
                                          TARGET_X, TARGET_X + TARGET_W - 1) &&
                            spans_overlap(int'(y_q[i*Y_W +: Y_W]),
                                          int'(y_q[i*Y_W +: Y_W]) + PROJ_H - 1,
                                          int'(pool.target_top_y),
                                          int'(pool.target_top_y) + TARGET_H - 1)) begin
                  en_d[i] = 1'b0;
                  if (pool.shield_active) blk_vec[i] = 1'b1;
                  else                    hit_vec[i] = 1'b1;
               end else begin
                  x_d[i*X_W +: X_W] = nx[X_W-1:0];
               end
            end
         end
      end

      // Spawn uses the pre-tick free mask, so a slot freed this tick waits a cycle.
      accept = pool.shoot && (cd_q == '0) && !full_q && alive_q && free_found;
      if (accept) begin
         en_d[free_idx]                    = 1'b1;
         x_d[int'(free_idx)*X_W +: X_W]    = X_W'(SPAWN_X);
         y_d[int'(free_idx)*Y_W +: Y_W]    = pool.shoot_y;
      end

      cd_d = cd_q;
      if (accept)                              cd_d = CD_W'(COOLDOWN);
      else if (pool.move_tick && cd_q != '0)   cd_d = cd_q - CD_W'(1);

      for (int i = 0; i < N_SLOTS; i++) begin
         if (hit_vec[i]) k++;
      end
      dmg      = 10'(k * DAMAGE);
      health_d = health_q;
      if (alive_q) begin
         health_d = ({2'b00, health_q} > dmg) ? 8'({2'b00, health_q} - dmg) : 8'd0;
      end
   end

   always_ff @(posedge single_pulse_clk or posedge reset) begin
      if (reset) begin
         en_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         cd_q      <= '0;
         health_q  <= 8'(HEALTH_MAX);
         hit_q     <= 1'b0;
         blocked_q <= 1'b0;
         alive_q   <= 1'b1;
         full_q    <= 1'b0;
      end else if (pool.clear) begin
         en_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         cd_q      <= '0;
         health_q  <= 8'(HEALTH_MAX);
         hit_q     <= 1'b0;
         blocked_q <= 1'b0;
         alive_q   <= 1'b1;
         full_q    <= 1'b0;
      end else begin
         en_q      <= en_d;
         x_q       <= x_d;
         y_q       <= y_d;
         cd_q      <= cd_d;
         health_q  <= health_d;
         hit_q     <= |hit_vec;
         blocked_q <= |blk_vec;
         alive_q   <= (health_d != 8'd0);
         full_q    <= &en_d;
      end
   end

   assign pool.slot_en = en_q;
   assign pool.slot_x  = x_q;
   assign pool.slot_y  = y_q;
   assign pool.hit     = hit_q;
   assign pool.blocked = blocked_q;
   assign pool.health  = health_q;
   assign pool.alive   = alive_q;
   assign pool.full    = full_q;
endmodule

// File: doc/projectile_pool.md
# projectile_pool

Parametrised projectile manager for the two-player Pokemon battle screen. It replaces the fixed 12-entry fireball/waterball enable-and-X-position buses with one reusable block, instantiated once per attacker. The block allocates projectile slots on shoot requests and advances them on a movement tick. It detects collisions against the opposing sprite, applies shield blocking, and maintains the defender's health with saturation. Its outputs feed the OLED display block and the health seven-segment block.

## Interface
Parameters:
- N_SLOTS, 12: number of projectile slots (1–32)
- X_W, 7: X coordinate width; Y width is fixed at 6
- SPAWN_X, 10: X a new projectile starts at
- DIR, 1: 1 = moves toward +X, 0 = moves toward −X
- SPEED, 1: pixels moved per move_tick
- TARGET_X, 74: left X of the defender sprite
- TARGET_W, 22: defender sprite width in pixels
- TARGET_H, 20: defender sprite height in pixels
- PROJ_H, 5: projectile height in pixels
- COOLDOWN, 8: move_ticks required between accepted shots
- HEALTH_MAX, 100: defender health after reset or clear
- DAMAGE, 5: health removed per unshielded hit

Ports:
- single_pulse_clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous game restart
- move_tick  in  1  one-cycle movement strobe (50 Hz-derived)
- shoot  in  1  one-cycle shot request
- shoot_y  in  6  top Y of the spawned projectile
- target_top_y  in  6  defender top Y
- shield_active  in  1  defender shield is up
- slot_en  out  N_SLOTS  active mask
- slot_x  out  N_SLOTS*X_W  packed X; slot i occupies bits [i*X_W +: X_W]
- slot_y  out  N_SLOTS*6  packed Y
- hit  out  1  one-cycle pulse when at least one unshielded hit occurs
- blocked  out  1  one-cycle pulse when at least one hit is shielded
- health  out  8  defender health
- alive  out  1  health != 0
- full  out  1  all slots active

## Operation
- **Reset (async) and clear (sync, highest priority):**
  - slot_en=0, slot_x=0, slot_y=0
  - hit=0, blocked=0
  - health=HEALTH_MAX, alive=1, full=0
  - cooldown counter=0
- **Shoot is accepted only if all of the following hold:**
  - cooldown=0
  - not full
  - alive
- **On acceptance:**
  - The lowest-index free slot gets en=1, x=SPAWN_X, y=shoot_y.
  - Cooldown loads COOLDOWN.
- **Rejected shots** are dropped silently; they are not queued.
- **Cooldown** decrements on each move_tick and saturates at 0.
- **On move_tick**, each slot active before this cycle:
  - Compute next x = x ± SPEED, in X_W+1 bits.
  - Out of screen: next x < 0 or ≥ 96 frees the slot.
  - Collision: next-x span [x, x+3] overlaps [TARGET_X, TARGET_X+TARGET_W−1] AND Y span [y, y+PROJ_H−1] overlaps [target_top_y, target_top_y+TARGET_H−1].
    - Either way the slot is freed.
    - If shield_active, it counts as blocked; otherwise it counts as a hit.
- **Health update:**
  - k = number of unshielded hits on this tick.
  - health ← max(0, health − k·DAMAGE), computed in 10 bits.
  - alive falls when health reaches 0.
- **Dead state:** while !alive, existing projectiles keep moving, but no new shots are accepted and no further damage is applied.

## Timing
- All outputs are registered.
- A shot accepted in cycle t is visible in slot_en at t+1.
- hit, blocked and health update in the cycle after the move_tick edge; hit and blocked are exactly 1 cycle wide.
- Shoot and move_tick in the same cycle: existing slots move; the new slot spawns at SPAWN_X unmoved. Cooldown loads COOLDOWN; the decrement is ignored.
- A slot freed on a tick is not reusable until the next cycle.
- full is registered and is recomputed from the next slot_en.
- clear together with any other input: clear wins.

## Structure
- Shared package pokemon_pkg holds:
  - SCREEN_W=96, SCREEN_H=64
  - PROJ_W=4
  - the default sprite dimensions
- Sub-module free_slot_finder: parametrised lowest-set-bit priority encoder over ~slot_en; outputs index and found.
- Hit counting is a popcount over the per-slot hit vector, done inline.

## Test plan
- **Spawn and move:** reset, shoot with shoot_y=20 → slot0 en, x=10, y=20; after 3 move_ticks x=13.
- **Cooldown and full:** with COOLDOWN=8, N_SLOTS=4:
  - 2 shoots 1 tick apart → only the first is accepted.
  - 4 shots spaced 8 ticks apart → full=1; a 5th shot is dropped and slot_en=4'hF.
- **Hit:** target_top_y=18, projectile at y=20 reaches x=71 → hit pulses 1 cycle, health 100→95, slot freed.
- **Blocked and miss:**
  - Same as the hit case with shield_active=1 → blocked pulses, health stays 100.
  - A projectile at y=50 passes the target and is freed at x≥96.
- **Simultaneous hits and saturation:** with health=5, two slots collide on one tick → health=0, alive=0; subsequent shoot requests are ignored.
- **Reset mid-flight:** assert clear with 3 slots active → all outputs return to reset values next cycle; assert async reset mid-cycle → outputs clear immediately.
